// File: rtl/count_sequencer.sv
// Command sequencer for the up/down counter: plays a table of {dir, len} entries
// onto the counter's en/up controls, with a one-tick idle gap between entries.
module count_sequencer #(
  parameter  int DEPTH  = 4,
  parameter  int LEN_W  = 8,
  parameter  int DATA_W = 16,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic              cfg_dir,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [DATA_W-1:0] cnt_value,
  output logic              cnt_en,
  output logic              cnt_up,
  output logic              busy,
  output logic              done,
  output logic              sat,
  output logic [IDX_W-1:0]  cur_idx
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic               cnt_en_q, cnt_en_d;
  logic               cnt_up_q, cnt_up_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sat_q, sat_d;
  logic               dir_q [DEPTH];
  logic               dir_d [DEPTH];
  logic [LEN_W-1:0]   len_q [DEPTH];
  logic [LEN_W-1:0]   len_d [DEPTH];

  logic [IDX_W-1:0]   next_idx;
  logic               at_end;
  logic               sat_hit;

  // cnt_up_q always mirrors the running entry's direction while in RUN.
  assign sat_hit  = cnt_up_q ? (cnt_value == {DATA_W{1'b1}}) : (cnt_value == '0);
  assign next_idx = cur_idx_q + IDX_W'(1);
  assign at_end   = (cur_idx_q == IDX_W'(DEPTH - 1)) || (len_q[next_idx] == '0);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_idx_d   = cur_idx_q;
    cnt_en_d    = cnt_en_q;
    cnt_up_d    = cnt_up_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sat_d       = sat_q;
    dir_d       = dir_q;
    len_d       = len_q;

    if (cfg_we && !busy_q) begin
      dir_d[cfg_addr] = cfg_dir;
      len_d[cfg_addr] = cfg_len;
    end

    if (abort) begin
      state_d  = IDLE;
      cnt_en_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sat_d = 1'b0;
            if (len_q[0] != '0) begin
              state_d     = RUN;
              remaining_d = len_q[0];
              cur_idx_d   = '0;
              cnt_en_d    = 1'b1;
              cnt_up_d    = dir_q[0];
              busy_d      = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (tick) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (sat_hit) begin
              sat_d = 1'b1;
            end
            if (sat_hit || (remaining_q == LEN_W'(1))) begin
              state_d  = GAP;
              cnt_en_d = 1'b0;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (!at_end) begin
              state_d     = RUN;
              cur_idx_d   = next_idx;
              remaining_d = len_q[next_idx];
              cnt_up_d    = dir_q[next_idx];
              cnt_en_d    = 1'b1;
            end else if (loop) begin
              state_d     = RUN;
              cur_idx_d   = '0;
              remaining_d = len_q[0];
              cnt_up_d    = dir_q[0];
              cnt_en_d    = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      cur_idx_q   <= '0;
      cnt_en_q    <= 1'b0;
      cnt_up_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dir_q[i] <= 1'b0;
        len_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_idx_q   <= cur_idx_d;
      cnt_en_q    <= cnt_en_d;
      cnt_up_q    <= cnt_up_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_up  = cnt_up_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sat     = sat_q;
  assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: cycle-exact vector table through a
// scoreboard queue, then multi-cycle program runs against a small counter model.
module tb_count_sequencer;

  localparam int DEPTH  = 4;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              rst, tick, cfg_we, cfg_dir, start, abort, loop;
  logic [IDX_W-1:0]  cfg_addr;
  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] cnt_value, vec_value, model_cnt;
  logic              use_model, model_load;
  logic              cnt_en, cnt_up, busy, done, sat;
  logic [IDX_W-1:0]  cur_idx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, tick, we;
    logic [1:0]  addr;
    logic        dir;
    logic [7:0]  len;
    logic        start, abort, loop;
    logic [15:0] val;
    logic [6:0]  exp;   // {cnt_en, cnt_up, busy, done, sat, cur_idx}
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] sb[$];

  count_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_dir(cfg_dir), .cfg_len(cfg_len), .start(start), .abort(abort),
    .loop(loop), .cnt_value(cnt_value), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .busy(busy), .done(done), .sat(sat), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  // Stand-in for the real counter: counts on tick cycles while enabled.
  always @(posedge clk) begin
    if (model_load) model_cnt <= 16'd100;
    else if (tick && cnt_en) model_cnt <= cnt_up ? model_cnt + 16'd1 : model_cnt - 16'd1;
  end

  assign cnt_value = use_model ? model_cnt : vec_value;

  task automatic addVec(input logic r, t, w, input logic [1:0] a, input logic d,
                        input logic [7:0] l, input logic s, ab, lp,
                        input logic [15:0] v, input logic [6:0] e);
    vec_t x;
    x.rst = r; x.tick = t; x.we = w; x.addr = a; x.dir = d; x.len = l;
    x.start = s; x.abort = ab; x.loop = lp; x.val = v; x.exp = e;
    vecs.push_back(x);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; tick = v.tick; cfg_we = v.we; cfg_addr = v.addr; cfg_dir = v.dir;
    cfg_len = v.len; start = v.start; abort = v.abort; loop = v.loop; vec_value = v.val;
    sb.push_back(v.exp);
  endtask

  task automatic checkOutput(input int id);
    logic [6:0] act, want;
    act  = {cnt_en, cnt_up, busy, done, sat, cur_idx};
    want = sb.pop_front();
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL vec%0d {en,up,busy,done,sat,idx}: got %b want %b", id, act, want);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic idleInputs();
    rst = 0; tick = 0; cfg_we = 0; cfg_addr = '0; cfg_dir = 0; cfg_len = '0;
    start = 0; abort = 0; loop = 0; vec_value = 16'd100;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic writeEntry(input logic [1:0] a, input logic d, input logic [7:0] l);
    cfg_we = 1; cfg_addr = a; cfg_dir = d; cfg_len = l;
    stepClock();
    cfg_we = 0;
  endtask

  task automatic resetAndLoad();
    rst = 1; model_load = 1;
    stepClock();
    rst = 0; model_load = 0;
  endtask

  initial begin
    int up_ticks, dn_ticks, gap_ticks, done_cnt;
    int done_before, done_after, gap_after, done_idx, max_idx;
    logic wrapped, done_seen;
    logic [IDX_W-1:0] prev_idx;

    idleInputs();
    use_model = 0;
    model_load = 1;

    // Cycle-exact table; rows give the outputs expected right after that edge.
    addVec(1,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_0_0_0_0_00);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_0_0_0_0_00);
    addVec(0,0,0,2'd0,0,8'd0, 1,0,0,16'd100,   7'b0_0_0_1_0_00);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_0_0_0_0_00);
    addVec(0,0,1,2'd0,1,8'd10,0,0,0,16'd100,   7'b0_0_0_0_0_00);
    addVec(0,0,0,2'd0,0,8'd0, 1,0,0,16'd100,   7'b1_1_1_0_0_00);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b1_1_1_0_0_00);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'hFFFF,  7'b0_1_1_0_1_00);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_1_1_0_1_00);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_1_0_1_1_00);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_1_0_0_1_00);
    addVec(0,0,0,2'd0,0,8'd0, 1,0,0,16'd100,   7'b1_1_1_0_0_00);
    addVec(0,0,0,2'd0,0,8'd0, 0,1,0,16'd100,   7'b0_1_0_0_0_00);
    addVec(0,0,1,2'd1,0,8'd2, 0,0,0,16'd100,   7'b0_1_0_0_0_00);
    addVec(0,0,1,2'd0,1,8'd1, 0,0,0,16'd100,   7'b0_1_0_0_0_00);
    addVec(0,0,0,2'd0,0,8'd0, 1,0,0,16'd100,   7'b1_1_1_0_0_00);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_1_1_0_0_00);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd101,   7'b1_0_1_0_0_01);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd101,   7'b1_0_1_0_0_01);
    addVec(0,1,0,2'd0,0,8'd0, 0,1,0,16'd100,   7'b0_0_0_0_0_01);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_0_0_0_0_01);
    addVec(0,0,0,2'd0,0,8'd0, 1,1,0,16'd100,   7'b0_0_0_0_0_01);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_0_0_0_0_01);
    addVec(0,1,0,2'd0,0,8'd0, 1,0,0,16'd100,   7'b1_1_1_0_0_00);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_1_1_0_0_00);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b1_0_1_0_0_01);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd0,     7'b0_0_1_0_1_01);
    addVec(0,1,0,2'd0,0,8'd0, 0,0,0,16'd0,     7'b0_0_0_1_1_01);
    addVec(0,0,0,2'd0,0,8'd0, 0,0,0,16'd100,   7'b0_0_0_0_1_01);
    addVec(0,0,0,2'd0,0,8'd0, 0,1,0,16'd100,   7'b0_0_0_0_1_01);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      stepClock();
      checkOutput(i);
    end
    idleInputs();
    use_model = 1;

    // Two-entry program with a sparse tick, checked against the counter model.
    resetAndLoad();
    writeEntry(2'd0, 1'b1, 8'd3);
    writeEntry(2'd1, 1'b0, 8'd2);
    writeEntry(2'd2, 1'b0, 8'd0);
    start = 1;
    stepClock();
    start = 0;
    checkValue("prog1 start en/busy/up", {29'd0, cnt_en, busy, cnt_up}, 32'd7);
    up_ticks = 0; dn_ticks = 0; gap_ticks = 0; done_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      tick = ((c % 4) == 3);
      if (tick && cnt_en && cnt_up) up_ticks++;
      if (tick && cnt_en && !cnt_up) dn_ticks++;
      if (tick && !cnt_en && busy) gap_ticks++;
      stepClock();
      if (done) done_cnt++;
    end
    tick = 0;
    checkValue("prog1 up ticks", up_ticks, 32'd3);
    checkValue("prog1 down ticks", dn_ticks, 32'd2);
    checkValue("prog1 gap ticks", gap_ticks, 32'd2);
    checkValue("prog1 done pulses", done_cnt, 32'd1);
    checkValue("prog1 busy after", {31'd0, busy}, 32'd0);
    checkValue("prog1 counter end", {16'd0, model_cnt}, 32'd101);

    // Looping program: one full wrap, then loop dropped for a final pass.
    resetAndLoad();
    writeEntry(2'd0, 1'b1, 8'd2);
    writeEntry(2'd1, 1'b0, 8'd2);
    writeEntry(2'd2, 1'b1, 8'd2);
    writeEntry(2'd3, 1'b0, 8'd2);
    loop = 1;
    start = 1;
    stepClock();
    start = 0;
    wrapped = 0; done_before = 0; done_after = 0; gap_after = 0; done_idx = 0;
    for (int c = 0; c < 400; c++) begin
      tick = ((c % 2) == 1);
      if (wrapped && tick && !cnt_en && busy) gap_after++;
      prev_idx = cur_idx;
      stepClock();
      if (done) begin
        if (!wrapped) done_before++;
        else begin
          done_after++;
          done_idx = int'(cur_idx);
        end
      end
      if (!wrapped && prev_idx == 2'd3 && cur_idx == 2'd0 && busy) begin
        wrapped = 1;
        loop = 0;
      end
      if (done_after > 0) break;
    end
    tick = 0;
    loop = 0;
    checkValue("loop wrapped to 0", {31'd0, wrapped}, 32'd1);
    checkValue("loop no done first pass", done_before, 32'd0);
    checkValue("loop done after pass 2", done_after, 32'd1);
    checkValue("loop gaps in pass 2", gap_after, 32'd4);
    checkValue("loop done idx", done_idx, 32'd3);
    checkValue("loop busy after", {31'd0, busy}, 32'd0);

    // Table write while busy must not truncate the program.
    resetAndLoad();
    writeEntry(2'd0, 1'b1, 8'd2);
    writeEntry(2'd1, 1'b0, 8'd2);
    writeEntry(2'd2, 1'b1, 8'd2);
    writeEntry(2'd3, 1'b0, 8'd0);
    start = 1;
    stepClock();
    start = 0;
    writeEntry(2'd2, 1'b0, 8'd0);
    max_idx = 0; done_seen = 0;
    for (int c = 0; c < 200; c++) begin
      tick = ((c % 2) == 1);
      stepClock();
      if (busy && int'(cur_idx) > max_idx) max_idx = int'(cur_idx);
      if (done) begin
        done_seen = 1;
        break;
      end
    end
    tick = 0;
    checkValue("we-busy max idx", max_idx, 32'd2);
    checkValue("we-busy done seen", {31'd0, done_seen}, 32'd1);

    // Synchronous reset mid-run clears outputs and the table.
    start = 1;
    stepClock();
    start = 0;
    tick = 1;
    stepClock();
    tick = 0;
    rst = 1;
    stepClock();
    rst = 0;
    checkValue("rst outputs", {25'd0, cnt_en, cnt_up, busy, done, sat, cur_idx}, 32'd0);
    start = 1;
    stepClock();
    start = 0;
    checkValue("rst table cleared done/busy/en", {29'd0, done, busy, cnt_en}, 32'd4);
    stepClock();
    checkValue("rst done one cycle", {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Programmable command sequencer for the 16-bit up/down counter datapath. It holds a small table of commands, each a direction and a tick count, and plays them in order by driving the counter's `en`/`up` controls. A one-tick idle gap separates entries, so the counter's consecutive-count acceleration restarts at every entry. Runs are terminated early by counter saturation. Sits between the board's control logic (start/abort/loop switches) and the counter instance.

## Interface
Parameters:
- `DEPTH`, 4: command table entries (power of 2, ≥2).
- `LEN_W`, 8: width of per-entry tick count.
- `DATA_W`, 16: counter value width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  one-cycle pulse. The counter updates on cycles with `tick=1` and `cnt_en=1`.
- `cfg_we`  in  1  table write strobe. Ignored while `busy=1`.
- `cfg_addr`  in  log2(DEPTH)  table write index.
- `cfg_dir`  in  1  entry direction (1 = up).
- `cfg_len`  in  LEN_W  entry tick count. 0 marks end of program.
- `start`  in  1  begin program at entry 0. Ignored while `busy=1`.
- `abort`  in  1  stop immediately.
- `loop`  in  1  at program end, restart at entry 0 instead of finishing. Sampled at the end of each pass.
- `cnt_value`  in  DATA_W  current counter output.
- `cnt_en`  out  1  counter enable (registered).
- `cnt_up`  out  1  counter direction (registered).
- `busy`  out  1  program running.
- `done`  out  1  one-cycle pulse at normal completion.
- `sat`  out  1  sticky: some entry ended on saturation. Cleared on `start`.
- `cur_idx`  out  log2(DEPTH)  entry being executed.

## Operation
- Table: DEPTH × {dir, len}, all zeros after reset. The write takes effect the cycle after `cfg_we`.
- States: IDLE, RUN, GAP.
- Priority each cycle: `rst` > `abort` > state logic.

IDLE (`cnt_en=0`, `busy=0`):
- On `start`, if entry0.len ≠ 0: load `remaining=len`, `cur_idx=0`, clear `sat`, go to RUN.
- On `start` with entry0.len = 0: assert `done` next cycle, stay in IDLE, clear `sat`.

RUN (`cnt_en=1`, `cnt_up=dir[cur_idx]`):
- On each `tick`, decrement `remaining`.
- Go to GAP when `remaining==1` at a tick.
- Also go to GAP early if, at a tick, `dir=1 && cnt_value=={DATA_W{1}}` or `dir=0 && cnt_value==0`. In this case set `sat`.

GAP (`cnt_en=0`):
- Wait for the next `tick`, then advance.
- Next index is `cur_idx+1`. Program end is reached if `cur_idx==DEPTH-1` or the next entry's len = 0.
- Not at program end: load the next entry, go to RUN.
- At program end with `loop=1`: go to entry 0, RUN.
- At program end with `loop=0`: go to IDLE, pulse `done`.

Abort: in any state go to IDLE next cycle with `cnt_en=0` and `busy=0`. No `done` pulse. `sat` holds.

`start` and `abort` in the same cycle: abort wins, nothing starts.

`remaining` is LEN_W bits. It never wraps, because len = 0 entries are never entered.

## Timing
- Reset values: `cnt_en=0`, `cnt_up=0`, `busy=0`, `done=0`, `sat=0`, `cur_idx=0`. State is IDLE and the table is cleared.
- `start` sampled at cycle T → `busy=1`, `cnt_en=1`, `cnt_up=dir0` at T+1.
- Entry with len L and no saturation:
  - `cnt_en` is high for exactly L tick cycles.
  - `cnt_en` falls the cycle after the L-th tick.
  - `cnt_en` stays low through exactly one tick cycle, then rises the cycle after that tick.
- `cnt_up` only changes while `cnt_en=0`, or at the RUN entry cycle.
- `done` is high for one cycle, the cycle after the final GAP tick. `busy` falls in the same cycle.
- `abort` at T → `cnt_en=0`, `busy=0` at T+1. A tick at T is still counted by the counter.
- `tick` with `start` in IDLE: the tick is not counted; execution begins at T+1.

## Test plan
1. Program {up,3},{down,2},len0; start; tick every 4 cycles with counter at 100 → `cnt_en` high across 3 ticks (up), 1 gap tick low, 2 ticks down. `done` pulses once and `busy=0` after. Counter ends at 101.
2. Entry0 len 0, start → `done` pulse at T+1, `busy` stays 0, `cnt_en` never asserts.
3. Entry {up,10} with `cnt_value=16'hFFFF` at first tick → RUN ends at that tick, `sat=1`, GAP, then `done`. Next `start` clears `sat`.
4. All 4 entries len 2, `loop=1` → after entry 3's gap, `cur_idx` returns to 0 and no `done`. Deassert `loop` → `done` after entry 3 of the next pass.
5. Abort mid-RUN of entry 1 → `cnt_en=0`, `busy=0` next cycle, no `done`. `start` in the same cycle as `abort` in IDLE → no start.
6. `cfg_we` while busy writing len 0 to entry 2 → ignored, entry 2 still executes. Sync `rst` mid-run → all outputs at reset values next cycle and table cleared.
